// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared floating-point format constants, converter state
//                encoding and operand class codes for the float<->int
//                conversion stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    // Single-precision field layout
    localparam int FP_PRECISION     = 32;
    localparam int FP_EXPONENT_SIZE = 8;
    localparam int FP_MANTISSA_SIZE = 23;
    localparam int FP_EXP_BIAS      = (2 ** (FP_EXPONENT_SIZE - 1)) - 1;

    // Converter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2,
        ST_DONE  = 2'd3
    } fp_state_t;

    // Operand classification
    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_DENORM = 3'd1,
        CLS_NAN    = 3'd2,
        CLS_INF    = 3'd3,
        CLS_NORMAL = 3'd4
    } fp_class_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : fp_unpack
//  Description : Combinational field splitter. Extracts sign and mantissa,
//                classifies the operand and produces the signed unbiased
//                exponent (two bits wider than the exponent field).
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_unpack
    import fp_pkg::*;
#(
    parameter int PRECISION     = FP_PRECISION,
    parameter int EXPONENT_SIZE = FP_EXPONENT_SIZE,
    parameter int MANTISSA_SIZE = FP_MANTISSA_SIZE,
    parameter int EXP_BIAS      = FP_EXP_BIAS
) (
    input  logic [PRECISION-1:0]            i_fp,
    output logic                            o_sign,
    output logic [MANTISSA_SIZE-1:0]        o_mant,
    output logic signed [EXPONENT_SIZE+1:0] o_exp,
    output fp_class_t                       o_class
);

    localparam int c_EW = EXPONENT_SIZE + 2;

    logic [EXPONENT_SIZE-1:0] w_exp_field;
    logic                     w_exp_zero;
    logic                     w_exp_ones;
    logic                     w_mant_zero;

    assign o_sign      = i_fp[PRECISION-1];
    assign w_exp_field = i_fp[PRECISION-2 -: EXPONENT_SIZE];
    assign o_mant      = i_fp[MANTISSA_SIZE-1:0];

    // Two guard bits keep both the full positive field range and the
    // most negative unbiased exponent representable.
    assign o_exp = $signed({2'b00, w_exp_field}) - $signed(c_EW'(EXP_BIAS));

    assign w_exp_zero  = (w_exp_field == '0);
    assign w_exp_ones  = &w_exp_field;
    assign w_mant_zero = (o_mant == '0);

    // Classify from the exponent extremes and mantissa emptiness
    always_comb begin
        o_class = CLS_NORMAL;
        if (w_exp_zero) begin
            o_class = w_mant_zero ? CLS_ZERO : CLS_DENORM;
        end else if (w_exp_ones) begin
            o_class = w_mant_zero ? CLS_INF : CLS_NAN;
        end
    end

endmodule : fp_unpack
`default_nettype wire

// File: rtl/fp_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : fp_to_int
//  Description : Iterative float to signed integer converter, round toward
//                zero. One-bit-per-clock shifter, valid/ready handshakes on
//                both sides, invalid/inexact flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_to_int
    import fp_pkg::*;
#(
    parameter int INT_SIZE      = 32,
    parameter int PRECISION     = FP_PRECISION,
    parameter int EXPONENT_SIZE = FP_EXPONENT_SIZE,
    parameter int MANTISSA_SIZE = FP_MANTISSA_SIZE,
    parameter int EXP_BIAS      = (2 ** (EXPONENT_SIZE - 1)) - 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PRECISION-1:0] fp_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INT_SIZE-1:0]  int_out,
    output logic                 flag_invalid,
    output logic                 flag_inexact
);

    localparam int c_SW = (INT_SIZE > MANTISSA_SIZE + 1) ? INT_SIZE : MANTISSA_SIZE + 1;
    localparam int c_EW = EXPONENT_SIZE + 2;
    localparam int c_DW = c_EW + 1;

    localparam logic signed [c_DW-1:0] c_EMAX    = c_DW'(INT_SIZE - 1);
    localparam logic signed [c_DW-1:0] c_MSZ     = c_DW'(MANTISSA_SIZE);
    localparam logic [c_DW-1:0]        c_CNT_ONE = c_DW'(1);
    localparam logic [INT_SIZE-1:0]    c_INT_MIN = {1'b1, {(INT_SIZE-1){1'b0}}};
    localparam logic [INT_SIZE-1:0]    c_INT_MAX = ~c_INT_MIN;

    // Unpacked operand
    logic                     w_sign;
    logic [MANTISSA_SIZE-1:0] w_mant;
    logic signed [c_EW-1:0]   w_exp;
    fp_class_t                w_class;

    // Accept-time decode
    logic signed [c_DW-1:0]   w_exp_x;
    logic signed [c_DW-1:0]   w_diff;
    logic                     w_left;
    logic [c_DW-1:0]          w_cnt_init;
    logic                     w_exact_min;
    logic                     w_overflow;
    logic                     w_do_shift;
    logic [INT_SIZE-1:0]      w_sat;
    logic [INT_SIZE-1:0]      w_mag;

    fp_state_t                r_state;
    fp_state_t                w_state_nxt;

    logic                     r_sign;
    logic [c_SW-1:0]          r_sr;
    logic                     r_left;
    logic [c_DW-1:0]          r_cnt;
    logic                     r_sticky;
    logic [INT_SIZE-1:0]      r_int_out;
    logic                     r_inv;
    logic                     r_inx;

    fp_unpack #(
        .PRECISION     (PRECISION),
        .EXPONENT_SIZE (EXPONENT_SIZE),
        .MANTISSA_SIZE (MANTISSA_SIZE),
        .EXP_BIAS      (EXP_BIAS)
    ) u_unpack (
        .i_fp    (fp_in),
        .o_sign  (w_sign),
        .o_mant  (w_mant),
        .o_exp   (w_exp),
        .o_class (w_class)
    );

    assign w_exp_x     = {w_exp[c_EW-1], w_exp};
    assign w_diff      = w_exp_x - c_MSZ;
    assign w_left      = ~w_diff[c_DW-1];
    assign w_cnt_init  = w_left ? w_diff : -w_diff;
    // -2^(INT_SIZE-1) is the one value at the top exponent that still fits
    assign w_exact_min = w_sign & (w_exp_x == c_EMAX) & (w_mant == '0);
    assign w_overflow  = (w_exp_x >= c_EMAX) & ~w_exact_min;
    assign w_do_shift  = (w_class == CLS_NORMAL) & ~w_exp_x[c_DW-1] & ~w_overflow;
    assign w_sat       = w_sign ? c_INT_MIN : c_INT_MAX;
    assign w_mag       = r_sr[INT_SIZE-1:0];

    assign int_out      = r_int_out;
    assign flag_invalid = r_inv;
    assign flag_inexact = r_inx;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs. The final shift and the exit from
    // SHIFT share one edge, and a zero-length shift skips SHIFT entirely,
    // so a normal operand takes n+2 cycles to reach DONE.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (!w_do_shift) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_cnt_init == '0) begin
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (r_cnt <= c_CNT_ONE) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: classify on accept, shift one bit per cycle, sign-apply at FIN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign    <= 1'b0;
            r_sr      <= '0;
            r_left    <= 1'b0;
            r_cnt     <= '0;
            r_sticky  <= 1'b0;
            r_int_out <= '0;
            r_inv     <= 1'b0;
            r_inx     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sign <= w_sign;
                        r_inv  <= 1'b0;
                        r_inx  <= 1'b0;
                        case (w_class)
                            CLS_ZERO: begin
                                r_int_out <= '0;
                            end
                            CLS_DENORM: begin
                                r_int_out <= '0;
                                r_inx     <= 1'b1;
                            end
                            CLS_NAN: begin
                                r_int_out <= c_INT_MIN;
                                r_inv     <= 1'b1;
                            end
                            CLS_INF: begin
                                r_int_out <= w_sat;
                                r_inv     <= 1'b1;
                            end
                            default: begin
                                if (w_exp_x[c_DW-1]) begin
                                    r_int_out <= '0;
                                    r_inx     <= 1'b1;
                                end else if (w_overflow) begin
                                    r_int_out <= w_sat;
                                    r_inv     <= 1'b1;
                                end else begin
                                    r_sr     <= c_SW'({1'b1, w_mant});
                                    r_left   <= w_left;
                                    r_cnt    <= w_cnt_init;
                                    r_sticky <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                        if (r_left) begin
                            r_sr <= {r_sr[c_SW-2:0], 1'b0};
                        end else begin
                            r_sr     <= {1'b0, r_sr[c_SW-1:1]};
                            r_sticky <= r_sticky | r_sr[0];
                        end
                    end
                end
                ST_FIN: begin
                    r_int_out <= r_sign ? -w_mag : w_mag;
                    r_inx     <= r_sticky;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : fp_to_int
`default_nettype wire

// File: tb/tb_fp_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_to_int
//  Description : Self-checking bench for fp_to_int: directed vector table,
//                backpressure and mid-operation reset sequences, and random
//                operands checked against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_to_int;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fp_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] int_out;
    logic        flag_invalid;
    logic        flag_inexact;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    fp_to_int dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fp_in        (fp_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .int_out      (int_out),
        .flag_invalid (flag_invalid),
        .flag_inexact (flag_inexact)
    );

    typedef struct {
        string       nm;
        logic [31:0] fp;
        logic [31:0] res;
        logic        inv;
        logic        inx;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference: value = 1.M * 2^e truncated toward zero, from the field rules
    function automatic void ref_model(input logic [31:0] f, output logic [31:0] res,
                                      output logic inv, output logic inx, output int lat);
        bit     s;
        int     ex;
        int     e;
        longint m;
        longint sig;
        longint mag;
        s   = f[31];
        ex  = int'(f[30:23]);
        m   = longint'(f[22:0]);
        res = 32'h0;
        inv = 1'b0;
        inx = 1'b0;
        lat = 1;
        if (ex == 0) begin
            inx = (m != 0);
        end else if (ex == 255) begin
            inv = 1'b1;
            res = (m != 0 || s) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            e = ex - 127;
            if (e < 0) begin
                inx = 1'b1;
            end else if (e >= 31 && !(s && e == 31 && m == 0)) begin
                inv = 1'b1;
                res = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                sig = m + (64'sd1 << 23);
                if (e >= 23) begin
                    mag = sig * (64'sd1 << (e - 23));
                    lat = (e - 23) + 2;
                end else begin
                    mag = sig / (64'sd1 << (23 - e));
                    inx = (sig % (64'sd1 << (23 - e))) != 0;
                    lat = (23 - e) + 2;
                end
                res = 32'(s ? -mag : mag);
            end
        end
    endfunction

    // Wait (bounded) for out_valid; latency counts the accept edge as cycle 1
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_conv(input logic [31:0] f, output logic [31:0] r,
                            output logic inv, output logic inx, output int lat);
        int k;
        @(negedge clk);
        fp_in     = f;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(lat);
        r   = int_out;
        inv = flag_invalid;
        inx = flag_inexact;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_and_check(input string nm, input logic [31:0] f, input logic [31:0] er,
                                 input logic ei, input logic ex, input int el);
        logic [31:0] r;
        logic        inv;
        logic        inx;
        int          lat;
        run_conv(f, r, inv, inx, lat);
        check({nm, " int_out"}, r, er);
        check({nm, " invalid"}, 32'(inv), 32'(ei));
        check({nm, " inexact"}, 32'(inx), 32'(ex));
        check({nm, " latency"}, 32'(lat), 32'(el));
    endtask

    initial begin
        logic [31:0] er;
        logic        ei;
        logic        ex;
        int          el;
        int          lat;

        vecs[0] = '{"one",      32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 25};
        vecs[1] = '{"m5p75",    32'hC0B8_0000, 32'hFFFF_FFFB, 1'b0, 1'b1, 23};
        vecs[2] = '{"m2p31",    32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 10};
        vecs[3] = '{"p2p31",    32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
        vecs[4] = '{"nan",      32'h7FC0_0000, 32'h8000_0000, 1'b1, 1'b0, 1};
        vecs[5] = '{"minf",     32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1};
        vecs[6] = '{"denorm",   32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1};
        vecs[7] = '{"mzero",    32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1};
        vecs[8] = '{"half",     32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        fp_in     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready",  32'(in_ready),     32'h1);
        check("reset out_valid", 32'(out_valid),    32'h0);
        check("reset int_out",   int_out,           32'h0);
        check("reset invalid",   32'(flag_invalid), 32'h0);
        check("reset inexact",   32'(flag_inexact), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_and_check(vecs[i].nm, vecs[i].fp, vecs[i].res, vecs[i].inv, vecs[i].inx, vecs[i].lat);
        end

        // Backpressure: 3.0 held in DONE while 10.0 waits on the input
        @(negedge clk);
        fp_in     = 32'h4040_0000;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        fp_in = 32'h4120_0000;
        wait_result(lat);
        check("bp first latency", 32'(lat), 32'd24);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp hold int_out",   int_out,           32'h3);
            check("bp hold out_valid", 32'(out_valid),    32'h1);
            check("bp hold in_ready",  32'(in_ready),     32'h0);
            check("bp hold flags",     32'({flag_invalid, flag_inexact}), 32'h0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp release out_valid", 32'(out_valid), 32'h0);
        check("bp release in_ready",  32'(in_ready),  32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp accepted in_ready", 32'(in_ready), 32'h0);
        wait_result(lat);
        check("bp second int_out", int_out,  32'h0000_000A);
        check("bp second latency", 32'(lat), 32'd22);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of a shift sequence
        @(negedge clk);
        fp_in    = 32'h3F80_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset out_valid", 32'(out_valid), 32'h0);
        check("midreset in_ready",  32'(in_ready),  32'h1);
        check("midreset int_out",   int_out,        32'h0);
        run_and_check("after reset ten", 32'h4120_0000, 32'h0000_000A, 1'b0, 1'b0, 22);

        // Random operands, mostly in the interesting exponent window
        for (int i = 0; i < 150; i++) begin
            logic [31:0] f;
            f = $urandom;
            if (i % 4 != 0) begin
                f[30:23] = 8'($urandom_range(100, 160));
            end
            ref_model(f, er, ei, ex, el);
            run_and_check($sformatf("rand%0d_%08h", i, f), f, er, ei, ex, el);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_fp_to_int
`default_nettype wire
